control_sequencer: RTL and testbench

Parametrised successor to the core's control FSM. It decodes opcode/funct3 and drives the RegisterFile, MemoryController, RD source selection, ProgramCounter, InstructionAddressMux, ALU, ImmediateFormer and BranchALU control lines. Additions over the current controller:
- memory ready/wait handshake with a watchdog timeout
- optional single-phase sub-word stores
- latched halt cause with priority encoding
- resume from ecall/ebreak
- retired-instruction counter

---
 rtl/control_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Control sequencer: decodes opcode/funct3 into datapath controls, sequences memory phases,
// latches halt causes by priority, supports ecall/ebreak resume and counts retired instructions.
package control_sequencer_pkg;

    typedef enum logic [1:0] {
        MM_NOP           = 2'd0,
        MM_LOAD          = 2'd1,
        MM_STORE_PRELOAD = 2'd2,
        MM_STORE         = 2'd3
    } MemoryMode_t;

    typedef enum logic {
        IAS_CURRENT_PC = 1'b0,
        IAS_NEXT_PC    = 1'b1
    } InstructionAddressSource_t;

    typedef enum logic {
        IFM_LUI   = 1'b0,
        IFM_AUIPC = 1'b1
    } ImmediateFormerMode_t;

    typedef enum logic [1:0] {
        BAM_INCREMENT = 2'd0,
        BAM_JAL       = 2'd1,
        BAM_JALR      = 2'd2,
        BAM_BRANCH    = 2'd3
    } BranchALUMode_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] HC_NONE          = 3'd0;
    localparam logic [2:0] HC_SYSTEM        = 3'd1;
    localparam logic [2:0] HC_BAD_OPCODE    = 3'd2;
    localparam logic [2:0] HC_BRANCH_FUNCT3 = 3'd3;
    localparam logic [2:0] HC_PC_MISALIGNED = 3'd4;
    localparam logic [2:0] HC_MEM_UNALIGNED = 3'd5;
    localparam logic [2:0] HC_MEM_FUNCT3    = 3'd6;
    localparam logic [2:0] HC_MEM_TIMEOUT   = 3'd7;

    localparam logic [1:0] RDS_MEM    = 2'd0;
    localparam logic [1:0] RDS_ALU    = 2'd1;
    localparam logic [1:0] RDS_IMM    = 2'd2;
    localparam logic [1:0] RDS_BRANCH = 2'd3;

endpackage

module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT       = 15,
    parameter int unsigned SUBWORD_STORE_RMW = 1,
    parameter int unsigned RETIRE_WIDTH      = 32
) (
    input  logic                        clock,
    input  logic                        nReset,
    input  logic [6:0]                  opcode,
    input  logic [2:0]                  funct3,
    input  logic                        memReady,
    input  logic                        branchALUBadFunct3,
    input  logic                        programCounterMisaligned,
    input  logic                        memoryUnalignedAccess,
    input  logic                        memoryBadFunct3,
    input  logic                        resume,
    output logic                        rdWriteEnable,
    output MemoryMode_t                 memoryMode,
    output logic [1:0]                  rdSource,
    output logic                        programCounterWriteEnable,
    output InstructionAddressSource_t   instructionAddressSource,
    output logic                        opImm,
    output ImmediateFormerMode_t        immediateFormerMode,
    output BranchALUMode_t              branchALUMode,
    output logic                        halted,
    output logic [2:0]                  haltCause,
    output logic [RETIRE_WIDTH-1:0]     retiredCount
);

    localparam int unsigned WAIT_W = 8;

    typedef enum logic [3:0] {
        S_INITIAL_FETCH = 4'b0001,
        S_FETCH_EXECUTE = 4'b0010,
        S_MEM_PHASE1    = 4'b0100,
        S_HALT          = 4'b1000
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              cause_q, cause_d;
    logic [WAIT_W-1:0]       wait_q, wait_d;
    logic                    p1_done_q, p1_done_d;
    logic [RETIRE_WIDTH-1:0] retire_q;

    logic is_load, is_store, mem_op, known_op, subword, two_phase;
    logic active, in_phase1, stall, timeout, bad_op;
    logic [2:0] cause_c;

    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign mem_op    = is_load | is_store;
    assign subword   = (funct3 == 3'b000) || (funct3 == 3'b001);
    assign two_phase = is_load | (is_store & subword & (SUBWORD_STORE_RMW != 0));
    assign known_op  = mem_op || (opcode == OPC_LUI) || (opcode == OPC_AUIPC)
                    || (opcode == OPC_JAL) || (opcode == OPC_JALR) || (opcode == OPC_BRANCH)
                    || (opcode == OPC_OPIMM) || (opcode == OPC_OP) || (opcode == OPC_FENCE)
                    || (opcode == OPC_SYSTEM);

    assign active    = (state_q == S_FETCH_EXECUTE) || (state_q == S_MEM_PHASE1);
    assign in_phase1 = (state_q == S_MEM_PHASE1)
                    || ((state_q == S_FETCH_EXECUTE) && two_phase && !p1_done_q);
    assign stall     = active && (mem_op || (state_q == S_MEM_PHASE1)) && !memReady;
    assign timeout   = stall && ((9'({1'b0, wait_q}) + 9'd1) >= 9'(MEM_TIMEOUT));
    assign bad_op    = !known_op || ((state_q == S_MEM_PHASE1) && !mem_op);

    // Halt cause priority: timeout > PC misaligned > unaligned > mem funct3 > branch funct3 > opcode > system
    always_comb begin
        cause_c = HC_NONE;
        if (timeout)                       cause_c = HC_MEM_TIMEOUT;
        else if (programCounterMisaligned) cause_c = HC_PC_MISALIGNED;
        else if (memoryUnalignedAccess)    cause_c = HC_MEM_UNALIGNED;
        else if (memoryBadFunct3)          cause_c = HC_MEM_FUNCT3;
        else if (branchALUBadFunct3)       cause_c = HC_BRANCH_FUNCT3;
        else if (bad_op)                   cause_c = HC_BAD_OPCODE;
        else if (opcode == OPC_SYSTEM)     cause_c = HC_SYSTEM;
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q   <= S_INITIAL_FETCH;
            cause_q   <= HC_NONE;
            wait_q    <= '0;
            p1_done_q <= 1'b0;
            retire_q  <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            wait_q    <= wait_d;
            p1_done_q <= p1_done_d;
            if ((state_q == S_FETCH_EXECUTE) && programCounterWriteEnable)
                retire_q <= retire_q + RETIRE_WIDTH'(1);
        end
    end

    always_comb begin
        state_d                   = state_q;
        cause_d                   = cause_q;
        wait_d                    = '0;
        p1_done_d                 = 1'b0;
        rdWriteEnable             = 1'b0;
        memoryMode                = MM_NOP;
        rdSource                  = RDS_MEM;
        programCounterWriteEnable = 1'b0;
        instructionAddressSource  = IAS_CURRENT_PC;
        opImm                     = 1'b0;
        immediateFormerMode       = IFM_LUI;
        branchALUMode             = BAM_INCREMENT;

        case (state_q)
            S_INITIAL_FETCH: state_d = S_FETCH_EXECUTE;

            S_FETCH_EXECUTE, S_MEM_PHASE1: begin
                if (cause_c != HC_NONE) begin
                    state_d = S_HALT;
                    cause_d = cause_c;
                end else if (in_phase1) begin
                    // First phase of a load or read-modify-write store
                    memoryMode = is_load ? MM_LOAD : MM_STORE_PRELOAD;
                    if (memReady) begin
                        state_d   = S_FETCH_EXECUTE;
                        p1_done_d = 1'b1;
                    end else begin
                        state_d = S_MEM_PHASE1;
                        wait_d  = wait_q + WAIT_W'(1);
                    end
                end else if (mem_op) begin
                    memoryMode = is_load ? MM_LOAD : MM_STORE;
                    if (memReady) begin
                        rdWriteEnable             = is_load;
                        programCounterWriteEnable = 1'b1;
                        instructionAddressSource  = IAS_NEXT_PC;
                    end else begin
                        wait_d    = wait_q + WAIT_W'(1);
                        p1_done_d = p1_done_q;
                    end
                end else begin
                    programCounterWriteEnable = 1'b1;
                    instructionAddressSource  = IAS_NEXT_PC;
                    case (opcode)
                        OPC_LUI: begin
                            rdWriteEnable = 1'b1;
                            rdSource      = RDS_IMM;
                        end
                        OPC_AUIPC: begin
                            rdWriteEnable       = 1'b1;
                            rdSource            = RDS_IMM;
                            immediateFormerMode = IFM_AUIPC;
                        end
                        OPC_JAL: begin
                            rdWriteEnable = 1'b1;
                            rdSource      = RDS_BRANCH;
                            branchALUMode = BAM_JAL;
                        end
                        OPC_JALR: begin
                            rdWriteEnable = 1'b1;
                            rdSource      = RDS_BRANCH;
                            branchALUMode = BAM_JALR;
                        end
                        OPC_BRANCH: branchALUMode = BAM_BRANCH;
                        OPC_OPIMM: begin
                            rdWriteEnable = 1'b1;
                            rdSource      = RDS_ALU;
                            opImm         = 1'b1;
                        end
                        OPC_OP: begin
                            rdWriteEnable = 1'b1;
                            rdSource      = RDS_ALU;
                        end
                        default: ;
                    endcase
                end
            end

            S_HALT: begin
                // Only a system halt can be resumed; it steps past the ecall/ebreak
                if (resume && (cause_q == HC_SYSTEM)) begin
                    programCounterWriteEnable = 1'b1;
                    instructionAddressSource  = IAS_NEXT_PC;
                    state_d                   = S_FETCH_EXECUTE;
                    cause_d                   = HC_NONE;
                end
            end

            default: state_d = S_INITIAL_FETCH;
        endcase
    end

    assign halted       = (state_q == S_HALT);
    assign haltCause    = cause_q;
    assign retiredCount = retire_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed per-cycle stimulus pushes expected controls,
// a negedge monitor pops and compares. Instance a: RMW stores, timeout 4; instance b: byte-enable stores.
module tb_control_sequencer;
    import control_sequencer_pkg::*;

    localparam logic [6:0] BAD = 7'b1111111;

    logic clock = 1'b0;
    logic nreset_a = 1'b0;
    logic nreset_b = 1'b0;
    logic [6:0] opcode = OPC_LUI;
    logic [2:0] funct3 = 3'd0;
    logic memReady = 1'b1;
    logic br_f3 = 1'b0, pc_mis = 1'b0, mem_ua = 1'b0, mem_f3 = 1'b0;
    logic resume = 1'b0;
    bit   sel = 1'b0;

    logic rdwe_a, pcwe_a, opimm_a, halted_a;
    MemoryMode_t mm_a;
    logic [1:0] rds_a;
    InstructionAddressSource_t ias_a;
    ImmediateFormerMode_t ifm_a;
    BranchALUMode_t bam_a;
    logic [2:0] hc_a;
    logic [31:0] ret_a;

    logic rdwe_b, pcwe_b, opimm_b, halted_b;
    MemoryMode_t mm_b;
    logic [1:0] rds_b;
    InstructionAddressSource_t ias_b;
    ImmediateFormerMode_t ifm_b;
    BranchALUMode_t bam_b;
    logic [2:0] hc_b;
    logic [31:0] ret_b;

    control_sequencer #(.MEM_TIMEOUT(4), .SUBWORD_STORE_RMW(1), .RETIRE_WIDTH(32)) dut_a (
        .clock(clock), .nReset(nreset_a), .opcode(opcode), .funct3(funct3), .memReady(memReady),
        .branchALUBadFunct3(br_f3), .programCounterMisaligned(pc_mis),
        .memoryUnalignedAccess(mem_ua), .memoryBadFunct3(mem_f3), .resume(resume),
        .rdWriteEnable(rdwe_a), .memoryMode(mm_a), .rdSource(rds_a),
        .programCounterWriteEnable(pcwe_a), .instructionAddressSource(ias_a), .opImm(opimm_a),
        .immediateFormerMode(ifm_a), .branchALUMode(bam_a), .halted(halted_a),
        .haltCause(hc_a), .retiredCount(ret_a)
    );

    control_sequencer #(.MEM_TIMEOUT(15), .SUBWORD_STORE_RMW(0), .RETIRE_WIDTH(32)) dut_b (
        .clock(clock), .nReset(nreset_b), .opcode(opcode), .funct3(funct3), .memReady(memReady),
        .branchALUBadFunct3(br_f3), .programCounterMisaligned(pc_mis),
        .memoryUnalignedAccess(mem_ua), .memoryBadFunct3(mem_f3), .resume(resume),
        .rdWriteEnable(rdwe_b), .memoryMode(mm_b), .rdSource(rds_b),
        .programCounterWriteEnable(pcwe_b), .instructionAddressSource(ias_b), .opImm(opimm_b),
        .immediateFormerMode(ifm_b), .branchALUMode(bam_b), .halted(halted_b),
        .haltCause(hc_b), .retiredCount(ret_b)
    );

    logic [14:0] ctl_a, ctl_b;
    assign ctl_a = {rdwe_a, mm_a, rds_a, pcwe_a, ias_a, opimm_a, ifm_a, bam_a, halted_a, hc_a};
    assign ctl_b = {rdwe_b, mm_b, rds_b, pcwe_b, ias_b, opimm_b, ifm_b, bam_b, halted_b, hc_b};

    always #5 clock = ~clock;

    typedef struct {
        bit          which;
        logic [14:0] ctl;
        logic [31:0] ret;
        string       name;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    // Expected control word: {rdwe, memMode, rdSrc, pcwe, ias, opImm, ifm, bam, halted, cause}
    function automatic logic [14:0] ex(logic rdwe, logic [1:0] mm, logic [1:0] rs, logic pc,
                                       logic ias, logic oi, logic ifm, logic [1:0] bam,
                                       logic h, logic [2:0] hc);
        return {rdwe, mm, rs, pc, ias, oi, ifm, bam, h, hc};
    endfunction

    task automatic cyc(input logic [6:0] op, input logic [2:0] f3, input logic rdy,
                       input logic [3:0] err, input logic rs, input logic rst,
                       input logic [14:0] ctl, input logic [31:0] ret, input string nm);
        exp_t e;
        @(posedge clock);
        #1;
        if (sel) nreset_b = rst;
        else     nreset_a = rst;
        opcode   = op;
        funct3   = f3;
        memReady = rdy;
        {br_f3, pc_mis, mem_ua, mem_f3} = err;
        resume   = rs;
        e.which = sel;
        e.ctl   = ctl;
        e.ret   = ret;
        e.name  = nm;
        sb.push_back(e);
    endtask

    always @(negedge clock) begin
        exp_t e;
        logic [14:0] gc;
        logic [31:0] gr;
        if (sb.size() > 0) begin
            e  = sb.pop_front();
            gc = e.which ? ctl_b : ctl_a;
            gr = e.which ? ret_b : ret_a;
            total++;
            if (gc !== e.ctl || gr !== e.ret) begin
                bad++;
                $display("FAIL %s: got ctl=%b retired=%0d, expected ctl=%b retired=%0d",
                         e.name, gc, gr, e.ctl, e.ret);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] z, lw_p, lw_c, st_c;
        z    = 15'd0;
        lw_p = ex(0, 2'd1, 2'd0, 0, 0, 0, 0, 2'd0, 0, 3'd0);
        lw_c = ex(1, 2'd1, 2'd0, 1, 1, 0, 0, 2'd0, 0, 3'd0);
        st_c = ex(0, 2'd3, 2'd0, 1, 1, 0, 0, 2'd0, 0, 3'd0);

        sel = 1'b0;
        cyc(OPC_LUI, 3'd0, 1, 4'h0, 0, 0, z, 0, "reset");
        cyc(OPC_LUI, 3'd0, 1, 4'h0, 0, 1, z, 0, "initial_fetch");
        cyc(OPC_LUI, 3'd0, 1, 4'h0, 0, 1, ex(1, 2'd0, 2'd2, 1, 1, 0, 0, 2'd0, 0, 3'd0), 0, "lui");
        cyc(OPC_OPIMM, 3'd0, 1, 4'h0, 0, 1, ex(1, 2'd0, 2'd1, 1, 1, 1, 0, 2'd0, 0, 3'd0), 1, "addi");
        cyc(OPC_AUIPC, 3'd0, 1, 4'h0, 0, 1, ex(1, 2'd0, 2'd2, 1, 1, 0, 1, 2'd0, 0, 3'd0), 2, "auipc");
        cyc(OPC_JAL, 3'd0, 1, 4'h0, 0, 1, ex(1, 2'd0, 2'd3, 1, 1, 0, 0, 2'd1, 0, 3'd0), 3, "jal");
        cyc(OPC_JALR, 3'd0, 1, 4'h0, 0, 1, ex(1, 2'd0, 2'd3, 1, 1, 0, 0, 2'd2, 0, 3'd0), 4, "jalr");
        cyc(OPC_BRANCH, 3'd0, 1, 4'h0, 0, 1, ex(0, 2'd0, 2'd0, 1, 1, 0, 0, 2'd3, 0, 3'd0), 5, "beq");
        cyc(OPC_OP, 3'd0, 1, 4'h0, 0, 1, ex(1, 2'd0, 2'd1, 1, 1, 0, 0, 2'd0, 0, 3'd0), 6, "add");

        cyc(OPC_LOAD, 3'd2, 0, 4'h0, 0, 1, lw_p, 7, "lw_stall1");
        cyc(OPC_LOAD, 3'd2, 0, 4'h0, 0, 1, lw_p, 7, "lw_stall2");
        cyc(OPC_LOAD, 3'd2, 0, 4'h0, 0, 1, lw_p, 7, "lw_stall3");
        cyc(OPC_LOAD, 3'd2, 1, 4'h0, 0, 1, lw_p, 7, "lw_phase1_ready");
        cyc(OPC_LOAD, 3'd2, 1, 4'h0, 0, 1, lw_c, 7, "lw_commit");

        cyc(OPC_STORE, 3'd0, 1, 4'h0, 0, 1, ex(0, 2'd2, 2'd0, 0, 0, 0, 0, 2'd0, 0, 3'd0), 8, "sb_preload");
        cyc(OPC_STORE, 3'd0, 1, 4'h0, 0, 1, st_c, 8, "sb_commit");
        cyc(OPC_STORE, 3'd2, 1, 4'h0, 0, 1, st_c, 9, "sw");
        cyc(OPC_STORE, 3'd2, 0, 4'h0, 0, 1, ex(0, 2'd3, 2'd0, 0, 0, 0, 0, 2'd0, 0, 3'd0), 10, "sw_stall");
        cyc(OPC_STORE, 3'd2, 1, 4'h0, 0, 1, st_c, 10, "sw_commit");
        cyc(OPC_FENCE, 3'd0, 1, 4'h0, 0, 1, ex(0, 2'd0, 2'd0, 1, 1, 0, 0, 2'd0, 0, 3'd0), 11, "fence");

        cyc(OPC_SYSTEM, 3'd0, 1, 4'h0, 0, 1, z, 12, "ecall_halting");
        cyc(OPC_SYSTEM, 3'd0, 1, 4'h0, 0, 1, ex(0, 2'd0, 2'd0, 0, 0, 0, 0, 2'd0, 1, 3'd1), 12, "halt_system");
        cyc(OPC_SYSTEM, 3'd0, 1, 4'h0, 1, 1, ex(0, 2'd0, 2'd0, 1, 1, 0, 0, 2'd0, 1, 3'd1), 12, "resume");
        cyc(OPC_OPIMM, 3'd0, 1, 4'h0, 0, 1, ex(1, 2'd0, 2'd1, 1, 1, 1, 0, 2'd0, 0, 3'd0), 12, "after_resume");

        cyc(OPC_LOAD, 3'd7, 1, 4'b0101, 0, 1, z, 13, "priority_halting");
        cyc(OPC_LOAD, 3'd7, 1, 4'b0101, 0, 1, ex(0, 2'd0, 2'd0, 0, 0, 0, 0, 2'd0, 1, 3'd4), 13, "halt_pc_misaligned");
        cyc(OPC_LOAD, 3'd7, 1, 4'h0, 1, 1, ex(0, 2'd0, 2'd0, 0, 0, 0, 0, 2'd0, 1, 3'd4), 13, "resume_ignored_c4");
        cyc(OPC_LOAD, 3'd0, 1, 4'h0, 0, 0, z, 0, "reset_in_halt");
        cyc(OPC_LUI, 3'd0, 1, 4'h0, 0, 1, z, 0, "initial_fetch2");
        cyc(BAD, 3'd0, 1, 4'h0, 0, 1, z, 0, "bad_opcode_halting");
        cyc(BAD, 3'd0, 1, 4'h0, 0, 1, ex(0, 2'd0, 2'd0, 0, 0, 0, 0, 2'd0, 1, 3'd2), 0, "halt_bad_opcode");

        cyc(OPC_LUI, 3'd0, 1, 4'h0, 0, 0, z, 0, "reset3");
        cyc(OPC_LUI, 3'd0, 1, 4'h0, 0, 1, z, 0, "initial_fetch3");
        cyc(OPC_LOAD, 3'd2, 0, 4'h0, 0, 1, lw_p, 0, "timeout_stall1");
        cyc(OPC_LOAD, 3'd2, 0, 4'h0, 0, 1, lw_p, 0, "timeout_stall2");
        cyc(OPC_LOAD, 3'd2, 0, 4'h0, 0, 1, lw_p, 0, "timeout_stall3");
        cyc(OPC_LOAD, 3'd2, 0, 4'h0, 0, 1, z, 0, "timeout_halting");
        cyc(OPC_LOAD, 3'd2, 0, 4'h0, 0, 1, ex(0, 2'd0, 2'd0, 0, 0, 0, 0, 2'd0, 1, 3'd7), 0, "halt_timeout");
        cyc(OPC_LOAD, 3'd2, 1, 4'h0, 1, 1, ex(0, 2'd0, 2'd0, 0, 0, 0, 0, 2'd0, 1, 3'd7), 0, "resume_ignored_c7");
        cyc(OPC_LUI, 3'd0, 1, 4'h0, 0, 0, z, 0, "reset_from_timeout");

        sel = 1'b1;
        cyc(OPC_LUI, 3'd0, 1, 4'h0, 0, 0, z, 0, "b_reset");
        cyc(OPC_LUI, 3'd0, 1, 4'h0, 0, 1, z, 0, "b_initial_fetch");
        cyc(OPC_STORE, 3'd0, 1, 4'h0, 0, 1, st_c, 0, "b_sb_single");
        cyc(OPC_STORE, 3'd1, 1, 4'h0, 0, 1, st_c, 1, "b_sh_single");
        cyc(OPC_STORE, 3'd2, 1, 4'h0, 0, 1, st_c, 2, "b_sw");
        cyc(OPC_LOAD, 3'd0, 1, 4'h0, 0, 1, lw_p, 3, "b_lb_phase1");
        cyc(OPC_LOAD, 3'd0, 1, 4'h0, 0, 1, lw_c, 3, "b_lb_commit");
        cyc(OPC_LUI, 3'd0, 1, 4'h0, 0, 1, ex(1, 2'd0, 2'd2, 1, 1, 0, 0, 2'd0, 0, 3'd0), 4, "b_lui");

        @(negedge clock);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
